// File: rtl/ram_wr_ctrl_pkg.sv
// Shared definitions for the RAM write controller and the ROM address sequencer:
// state encodings and default bus widths.
package ram_wr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 24;

endpackage

// File: rtl/ram_rd_tick.sv
// Read hold-period counter: counts 0..CNT_MAX while enabled, freezes when not,
// clears synchronously, and flags the last count of each period with a tick.
module ram_rd_tick
  import ram_wr_ctrl_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = 24'd9_999_999
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_max;

  assign at_max = (cnt_q == CNT_MAX);
  // Tick only while counting, so a counter frozen at CNT_MAX cannot re-fire.
  assign tick   = en && at_max;

  // Next count: clear wins, otherwise advance and roll over at CNT_MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_max ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ram_wr_ctrl.sv
// RAM fill / playback controller. A key_wr pulse writes addr+INIT_VAL into every
// RAM location in one burst; a key_rd pulse plays the RAM back one address per
// hold period, and further key_rd pulses toggle pause. All outputs are registered.
//
// Key inputs are single-cycle pulses from the debouncers; there is no handshake.
// A pulse is acted on at the clock edge that samples it, and key_wr has priority
// over key_rd wherever both are accepted.
module ram_wr_ctrl
  import ram_wr_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [CNT_W-1:0]  CNT_MAX  = 24'd9_999_999,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              key_wr,
  input  logic              key_rd,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output state_t            state_dbg
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t              state_q,   state_d;
  logic                wr_en_q,   wr_en_d;
  logic                rd_en_q,   rd_en_d;
  logic                busy_q,    busy_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic                cnt_en;
  logic                cnt_clr;
  logic                tick;

  // The period counter runs only in READ when no key pulse is changing state;
  // it is cleared on every entry to READ from IDLE and on every jump to WRITE.
  assign cnt_en  = (state_q == ST_READ) && !key_wr && !key_rd;
  assign cnt_clr = (state_q != ST_WRITE) &&
                   (key_wr || ((state_q == ST_IDLE) && key_rd));

  ram_rd_tick #(
    .CNT_MAX (CNT_MAX)
  ) u_rd_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (cnt_en),
    .clr     (cnt_clr),
    .tick    (tick)
  );

  // Next-state and next-output logic for the fill/playback FSM.
  always_comb begin
    state_d = state_q;
    wr_en_d = wr_en_q;
    rd_en_d = rd_en_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (key_wr) begin
          state_d = ST_WRITE;
          wr_en_d = 1'b1;
          busy_d  = 1'b1;
          addr_d  = '0;
        end else if (key_rd) begin
          state_d = ST_READ;
          rd_en_d = 1'b1;
          addr_d  = '0;
        end
      end
      ST_WRITE: begin
        if (addr_q == ADDR_LAST) begin
          state_d = ST_IDLE;
          wr_en_d = 1'b0;
          busy_d  = 1'b0;
          addr_d  = '0;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      ST_READ: begin
        if (key_wr) begin
          state_d = ST_WRITE;
          wr_en_d = 1'b1;
          rd_en_d = 1'b0;
          busy_d  = 1'b1;
          addr_d  = '0;
        end else if (key_rd) begin
          state_d = ST_PAUSE;
          rd_en_d = 1'b0;
        end else if (tick) begin
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      ST_PAUSE: begin
        if (key_wr) begin
          state_d = ST_WRITE;
          wr_en_d = 1'b1;
          busy_d  = 1'b1;
          addr_d  = '0;
        end else if (key_rd) begin
          state_d = ST_READ;
          rd_en_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Write data always tracks the address, so it is correct on every write cycle.
    wr_data_d = DATA_W'(addr_d) + INIT_VAL;
  end

  // FSM state and registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= INIT_VAL;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign busy      = busy_q;
  assign addr      = addr_q;
  assign wr_data   = wr_data_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ram_wr_ctrl.sv
// Bench for ram_wr_ctrl: directed key sequences, a behavioural model of the
// fill/playback rules checked every cycle, a RAM model, and literal checkpoints.
module tb_ram_wr_ctrl;

  localparam logic [23:0] CNT_MAX  = 24'd99;
  localparam logic [7:0]  INIT_VAL = 8'h10;
  localparam int HOLD = 100;  // CNT_MAX + 1

  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_PLAY = 2;
  localparam int M_HOLD = 3;

  logic       sys_clk;
  logic       sys_rst;
  logic       key_wr;
  logic       key_rd;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  ram_wr_ctrl #(
    .ADDR_W   (8),
    .DATA_W   (8),
    .CNT_MAX  (CNT_MAX),
    .INIT_VAL (INIT_VAL)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_wr    (key_wr),
    .key_rd    (key_rd),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .addr      (addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    sys_clk = 1'b0;
    forever #10 sys_clk = ~sys_clk;
  end

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_mode;
  logic [7:0] m_addr;
  int         m_cnt;
  bit         m_fresh;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_mode = M_IDLE; m_addr = 8'd0; m_cnt = 0; m_fresh = 1'b1;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (key_wr)      begin m_mode = M_FILL; m_addr = 0; m_fresh = 0; end
          else if (key_rd) begin m_mode = M_PLAY; m_addr = 0; m_cnt = 0; m_fresh = 0; end
        end
        M_FILL: begin
          if (m_addr == 8'd255) begin m_mode = M_IDLE; m_addr = 0; end
          else m_addr = m_addr + 8'd1;
        end
        M_PLAY: begin
          if (key_wr)      begin m_mode = M_FILL; m_addr = 0; m_cnt = 0; end
          else if (key_rd) m_mode = M_HOLD;
          else begin
            m_cnt = (m_cnt + 1) % HOLD;
            if (m_cnt == 0) m_addr = m_addr + 8'd1;
          end
        end
        default: begin
          if (key_wr)      begin m_mode = M_FILL; m_addr = 0; m_cnt = 0; end
          else if (key_rd) m_mode = M_PLAY;
        end
      endcase
    end
  end

  // ---------------- RAM model ----------------
  logic [7:0] ram [256];
  bit         filled = 1'b0;

  always @(posedge sys_clk) begin
    if (wr_en) begin
      ram[addr] <= wr_data;
      if (addr == 8'd255) filled <= 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge sys_clk) begin
    logic [7:0] exp_data;
    exp_data = m_addr + INIT_VAL;
    chk("wr_en", wr_en, m_mode == M_FILL);
    chk("rd_en", rd_en, m_mode == M_PLAY);
    chk("busy",  busy,  m_mode == M_FILL);
    chk("addr",  addr,  m_addr);
    chk("state", state_dbg, m_mode);
    if (m_mode == M_FILL || m_fresh) chk("wr_data", wr_data, exp_data);
    if (rd_en && filled) begin
      exp_data = addr + 8'h10;
      chk("ram_rd", ram[addr], exp_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick_n(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  // Called at posedge+2; the pulse is sampled by the next edge.
  task automatic pulse(input bit w, input bit r);
    key_wr = w;
    key_rd = r;
    @(posedge sys_clk);
    #2;
    key_wr = 1'b0;
    key_rd = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_wr, n_busy, first_a, first_d, last_a, last_d, k;
    bit found;

    sys_rst = 1'b1;
    key_wr  = 1'b0;
    key_rd  = 1'b0;

    // 1. reset, then idle with no keys
    #30 sys_rst = 1'b0;
    tick_n(10000);
    chk("t1_addr", addr, 8'd0);
    chk("t1_wr_data", wr_data, 8'h10);
    chk("t1_idle", {wr_en, rd_en, busy, state_dbg}, 5'd0);

    // 2. fill
    pulse(1'b1, 1'b0);
    n_wr = 0; n_busy = 0; first_a = -1; first_d = -1; last_a = -1; last_d = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (busy) n_busy++;
      if (wr_en) begin
        if (n_wr == 0) begin first_a = addr; first_d = wr_data; end
        last_a = addr; last_d = wr_data;
        n_wr++;
      end
    end
    chk("t2_writes", n_wr, 256);
    chk("t2_busy_cycles", n_busy, 256);
    chk("t2_first_addr", first_a, 0);
    chk("t2_first_data", first_d, 32'h10);
    chk("t2_last_addr", last_a, 255);
    chk("t2_last_data", last_d, 32'h0F);
    chk("t2_idle", state_dbg, 2'd0);
    @(posedge sys_clk); #2;

    // 3. playback, one address per 100 cycles, wrap after 25600
    pulse(1'b0, 1'b1);
    chk("t3_rd_en", rd_en, 1'b1);
    chk("t3_addr0", addr, 8'd0);
    tick_n(99);
    chk("t3_addr0_held", addr, 8'd0);
    tick_n(1);
    chk("t3_addr1", addr, 8'd1);
    tick_n(25499);
    chk("t3_addr255", addr, 8'd255);
    tick_n(1);
    chk("t3_wrap", addr, 8'd0);
    chk("t3_wrap_rd_en", rd_en, 1'b1);

    // 4. pause at cnt=40, addr=7; resume
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (m_mode == M_PLAY && m_cnt == 40 && m_addr == 8'd7) found = 1'b1;
      else tick_n(1);
    end
    chk("t4_reach_pause_point", found, 1'b1);
    pulse(1'b0, 1'b1);
    chk("t4_paused_rd_en", rd_en, 1'b0);
    chk("t4_paused_addr", addr, 8'd7);
    tick_n(10000);
    chk("t4_still_paused_rd_en", rd_en, 1'b0);
    chk("t4_still_paused_addr", addr, 8'd7);
    pulse(1'b0, 1'b1);
    chk("t4_resume_rd_en", rd_en, 1'b1);
    chk("t4_resume_addr", addr, 8'd7);
    k = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge sys_clk); #2;
      k++;
      if (addr == 8'd8) break;
    end
    chk("t4_resume_latency", k, 60);

    // 5. both keys during READ: write wins; extra keys during fill ignored
    pulse(1'b1, 1'b1);
    chk("t5_wr_en", wr_en, 1'b1);
    chk("t5_rd_en", rd_en, 1'b0);
    chk("t5_addr", addr, 8'd0);
    chk("t5_busy", busy, 1'b1);
    n_wr = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (wr_en) n_wr++;
      key_wr = (i == 50) || (i == 200);
      key_rd = (i == 50) || (i == 120);
    end
    key_wr = 1'b0;
    key_rd = 1'b0;
    chk("t5_writes", n_wr, 256);
    chk("t5_idle", state_dbg, 2'd0);
    @(posedge sys_clk); #2;

    // 6. asynchronous reset mid-fill
    pulse(1'b1, 1'b0);
    tick_n(100);
    chk("t6_addr100", addr, 8'd100);
    #3 sys_rst = 1'b1;
    #1;
    chk("t6_async_wr_en", wr_en, 1'b0);
    chk("t6_async_busy", busy, 1'b0);
    chk("t6_async_addr", addr, 8'd0);
    chk("t6_async_wr_data", wr_data, 8'h10);
    chk("t6_async_rd_en", rd_en, 1'b0);
    @(posedge sys_clk); #2;
    sys_rst = 1'b0;
    tick_n(5);
    chk("t6_state_idle", state_dbg, 2'd0);
    chk("t6_no_write", wr_en, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
